// File: rtl/seq_adder_sub.sv
// seq_adder_sub: multi-cycle adder/subtractor that processes CHUNK bits per
// clock, LSB slice first, rippling the carry between cycles.
//
// Parameters:
//   WIDTH  operand/result width in bits
//   CHUNK  bits added per cycle (WIDTH must be a multiple of CHUNK)
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   start  request a new operation (accepted in IDLE or DONE)
//   A, B   operands
//   Cin    carry-in, add mode only
//   sub    0 = A+B+Cin, 1 = A-B
//   busy   high while slices are being processed
//   done   one-cycle pulse when SUM/Cout/ovf have just been updated
//   SUM    registered result
//   Cout   registered carry out of the MSB (subtract: 1 = no borrow)
//   ovf    registered two's-complement overflow
module seq_adder_sub #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] SUM,
    output logic             Cout,
    output logic             ovf
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("seq_adder_sub: WIDTH must be a multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;     // effective second operand (B or ~B)
    logic [WIDTH-1:0] acc;       // slices of the result produced so far
    logic [WIDTH-1:0] acc_next;
    logic [CHUNK-1:0] a_slice;
    logic [CHUNK-1:0] b_slice;
    logic [CHUNK:0]   slice_sum;
    logic             last;
    logic             accept;

    assign accept = start && (state == IDLE || state == DONE);
    assign last   = (cnt == CW'(N - 1));
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    // Slice selection and merge use constant part-selects inside a loop so
    // every index stays in range for any legal WIDTH/CHUNK pair.
    always_comb begin
        a_slice = '0;
        b_slice = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (cnt == CW'(i)) begin
                a_slice = a_reg[i*CHUNK +: CHUNK];
                b_slice = b_reg[i*CHUNK +: CHUNK];
            end
        end
        slice_sum = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK{1'b0}}, carry};
        acc_next  = acc;
        for (int unsigned i = 0; i < N; i++) begin
            if (cnt == CW'(i)) begin
                acc_next[i*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            carry <= 1'b0;
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            SUM   <= '0;
            Cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            cnt   <= '0;
            acc   <= '0;
            a_reg <= A;
            b_reg <= sub ? ~B : B;
            carry <= sub ? 1'b1 : Cin;
        end else if (state == RUN) begin
            cnt   <= cnt + 1'b1;
            carry <= slice_sum[CHUNK];
            acc   <= acc_next;
            if (last) begin
                SUM  <= acc_next;
                Cout <= slice_sum[CHUNK];
                ovf  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                        (acc_next[WIDTH-1] != a_reg[WIDTH-1]);
            end
        end
    end

endmodule
